// File: rtl/ram_if_pkg.sv
// Shared definitions for the store read-modify-write engine: store size
// codes, FSM state encoding and small elaboration-time helpers.
package ram_if_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Byte count named by a size code, before clamping to the RAM word.
  function automatic int size_bytes(input size_e sz);
    case (sz)
      SZ_B:    return 1;
      SZ_H:    return 2;
      SZ_W:    return 4;
      default: return 8;
    endcase
  endfunction

endpackage

// File: rtl/store_rmw_ctrl_if.sv
// LSU request/status and RAM port bundle of the store engine.
// master = LSU and RAM side, slave = store engine.
interface store_rmw_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int LSB = ram_if_pkg::clog2(DATA_W / 8);

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic [1:0]            req_size;
  logic [DATA_W-1:0]     req_data;

  logic [ADDR_W-LSB-1:0] ram_addr;
  logic                  ram_rd_en;
  logic [DATA_W-1:0]     ram_rdata;
  logic                  ram_we;
  logic [DATA_W-1:0]     ram_wdata;

  logic                  done;
  logic                  split;
  logic                  misalign;
  logic                  busy;

  modport master (
    output req_valid, req_addr, req_size, req_data, ram_rdata,
    input  req_ready, ram_addr, ram_rd_en, ram_we, ram_wdata,
    input  done, split, misalign, busy
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_data, ram_rdata,
    output req_ready, ram_addr, ram_rd_en, ram_we, ram_wdata,
    output done, split, misalign, busy
  );

endinterface

// File: rtl/store_lane_merge.sv
// Combinational byte-lane merge for one RMW phase: builds the lane mask of
// the bytes this phase writes and overlays the aligned store data on the
// word read back from RAM.
module store_lane_merge
#(
  parameter  int DATA_W = 32,
  localparam int B      = DATA_W / 8,
  localparam int LSB    = ram_if_pkg::clog2(DATA_W / 8)
) (
  input  logic [LSB-1:0]    off,
  input  logic [LSB:0]      n,
  input  logic              phase,
  input  logic [DATA_W-1:0] req_data,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [B-1:0]      mask,
  output logic              full,
  output logic [DATA_W-1:0] merged
);

  logic [LSB:0]      last;
  logic [DATA_W-1:0] shifted;

  // Lane selection and byte overlay for the current phase.
  // NOTE: every output gets a default before any conditional logic, so no latch can be inferred.
  always_comb begin
    mask    = '0;
    merged  = '0;
    last    = {1'b0, off} + n - (LSB+1)'(1);
    shifted = phase ? (req_data >> (8 * (B - int'(off))))
                    : (req_data << (8 * int'(off)));
    for (int i = 0; i < B; i++) begin
      if (!phase) mask[i] = (i >= int'(off)) && (i <= int'(last));
      else        mask[i] = (int'(last) >= B) && (i <= int'(last) - B);
      merged[8*i +: 8] = mask[i] ? shifted[8*i +: 8] : ram_rdata[8*i +: 8];
    end
    full = &mask;
  end

endmodule

// File: rtl/store_rmw_ctrl.sv
// Sequential store engine: accepts one byte/half/word/dword store at a time
// and performs read-modify-write on the RAM word(s) it touches, splitting
// stores that cross a word boundary into two phases.
module store_rmw_ctrl
  import ram_if_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int RD_LAT      = 1,
  parameter int ALLOW_SPLIT = 1
) (
  input logic             clk,
  input logic             rst,
  store_rmw_ctrl_if.slave bus
);

  localparam int B     = DATA_W / 8;
  localparam int LSB   = clog2(B);
  localparam int WA_W  = ADDR_W - LSB;
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);
  localparam bit SPLIT_EN = (ALLOW_SPLIT != 0);

  logic [2:0]        state;
  logic              phase;
  logic [CNT_W-1:0]  wait_cnt;

  logic [WA_W-1:0]   word_addr;
  logic [LSB-1:0]    off;
  logic [LSB:0]      n;
  logic [DATA_W-1:0] data;

  logic [LSB-1:0]    off_in;
  logic [LSB:0]      n_in;
  logic [LSB-1:0]    m_off;
  logic [LSB:0]      m_n;
  logic              m_phase;
  logic [B-1:0]      mask;
  logic              full;
  logic [DATA_W-1:0] merged;
  logic              crosses;

  // Decode the incoming request: byte offset and clamped byte count.
  always_comb begin
    off_in = bus.req_addr[LSB-1:0];
    n_in   = (LSB+1)'((size_bytes(size_e'(bus.req_size)) > B) ? B
                                                             : size_bytes(size_e'(bus.req_size)));
  end

  // In IDLE the merge sees the incoming request so its full flag picks the
  // first state; otherwise it works on the latched request and current phase.
  always_comb begin
    if (state == ST_IDLE) begin
      m_off   = off_in;
      m_n     = n_in;
      m_phase = 1'b0;
    end else begin
      m_off   = off;
      m_n     = n;
      m_phase = phase;
    end
  end

  store_lane_merge #(.DATA_W(DATA_W)) u_merge (
    .off       (m_off),
    .n         (m_n),
    .phase     (m_phase),
    .req_data  (data),
    .ram_rdata (bus.ram_rdata),
    .mask      (mask),
    .full      (full),
    .merged    (merged)
  );

  // The store spills into the next word when off + n runs past the last lane.
  assign crosses = (int'(off) + int'(n)) > B;

  // Control FSM: per phase RD, optional WAIT, then WR; DONE after the last phase.
  // A phase-2 mask covers at most B-1 lanes, so only phase 1 can skip the read.
  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      phase    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            phase <= 1'b0;
            state <= full ? ST_WR : ST_RD;
          end
        end
        ST_RD: begin
          if (RD_LAT <= 1) begin
            state <= ST_WR;
          end else begin
            wait_cnt <= WAIT_LOAD;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) state <= ST_WR;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        ST_WR: begin
          if (!phase && SPLIT_EN && crosses) begin
            phase <= 1'b1;
            state <= ST_RD;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Capture the request on acceptance.
  // NOTE: these registers have no reset; they are only read while busy, which is reached only through a fresh capture.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && bus.req_valid) begin
      word_addr <= bus.req_addr[ADDR_W-1:LSB];
      off       <= off_in;
      n         <= n_in;
      data      <= bus.req_data;
    end
  end

  // Drive the RAM port and status; the bus stays at zero outside RD/WR.
  always_comb begin
    bus.req_ready = (state == ST_IDLE);
    bus.busy      = (state != ST_IDLE);
    bus.ram_rd_en = (state == ST_RD);
    bus.ram_we    = (state == ST_WR) && (|mask);
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (state == ST_RD || state == ST_WR)
      bus.ram_addr = word_addr + {{(WA_W-1){1'b0}}, phase};
    if (state == ST_WR)
      bus.ram_wdata = merged;
    bus.done      = (state == ST_DONE);
    bus.split     = (state == ST_DONE) && phase;
    bus.misalign  = (state == ST_DONE) && !SPLIT_EN && crosses;
  end

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Directed bench for store_rmw_ctrl. Three engines share one clock:
// dut0 (RD_LAT=1, split on), dut1 (RD_LAT=3, split on), dut2 (RD_LAT=1, split off),
// each with its own behavioural RAM.
module tb_store_rmw_ctrl;
  import ram_if_pkg::*;

  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  store_rmw_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();
  store_rmw_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus1 ();
  store_rmw_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus2 ();

  store_rmw_ctrl #(.DATA_W(32), .ADDR_W(32), .RD_LAT(1), .ALLOW_SPLIT(1))
    dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  store_rmw_ctrl #(.DATA_W(32), .ADDR_W(32), .RD_LAT(3), .ALLOW_SPLIT(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  store_rmw_ctrl #(.DATA_W(32), .ADDR_W(32), .RD_LAT(1), .ALLOW_SPLIT(0))
    dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  // Shared request fields; each engine has its own valid.
  logic [ND-1:0] req_valid_v;
  logic [31:0]   t_addr;
  logic [1:0]    t_size;
  logic [31:0]   t_data;

  assign bus0.req_valid = req_valid_v[0];
  assign bus1.req_valid = req_valid_v[1];
  assign bus2.req_valid = req_valid_v[2];
  assign bus0.req_addr = t_addr;  assign bus1.req_addr = t_addr;  assign bus2.req_addr = t_addr;
  assign bus0.req_size = t_size;  assign bus1.req_size = t_size;  assign bus2.req_size = t_size;
  assign bus0.req_data = t_data;  assign bus1.req_data = t_data;  assign bus2.req_data = t_data;

  logic [ND-1:0] ready_v, busy_v, rd_v, we_v, done_v, split_v, mis_v;
  logic [29:0]   raddr_v [ND];
  logic [31:0]   wdata_v [ND];

  assign ready_v = {bus2.req_ready, bus1.req_ready, bus0.req_ready};
  assign busy_v  = {bus2.busy,      bus1.busy,      bus0.busy};
  assign rd_v    = {bus2.ram_rd_en, bus1.ram_rd_en, bus0.ram_rd_en};
  assign we_v    = {bus2.ram_we,    bus1.ram_we,    bus0.ram_we};
  assign done_v  = {bus2.done,      bus1.done,      bus0.done};
  assign split_v = {bus2.split,     bus1.split,     bus0.split};
  assign mis_v   = {bus2.misalign,  bus1.misalign,  bus0.misalign};
  assign raddr_v[0] = bus0.ram_addr;  assign wdata_v[0] = bus0.ram_wdata;
  assign raddr_v[1] = bus1.ram_addr;  assign wdata_v[1] = bus1.ram_wdata;
  assign raddr_v[2] = bus2.ram_addr;  assign wdata_v[2] = bus2.ram_wdata;

  // Behavioural RAMs: sparse storage keyed by {engine, word address},
  // read data delayed through a per-engine pipeline.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] pipe [ND][4];

  function automatic logic [31:0] key(input int d, input logic [29:0] a);
    logic [1:0] dd;
    dd = d[1:0];
    return {dd, a};
  endfunction

  function automatic logic [31:0] mem_rd(input int d, input logic [29:0] a);
    if (mem.exists(key(d, a))) return mem[key(d, a)];
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      pipe[d][0] <= rd_v[d] ? mem_rd(d, raddr_v[d]) : 32'h0;
      for (int k = 1; k < 4; k++) pipe[d][k] <= pipe[d][k-1];
      if (we_v[d]) mem[key(d, raddr_v[d])] = wdata_v[d];
    end
  end

  assign bus0.ram_rdata = pipe[0][0];
  assign bus1.ram_rdata = pipe[1][2];
  assign bus2.ram_rdata = pipe[2][0];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transaction log filled by observe(); cycle 1 is the cycle after acceptance.
  int          rd_n, we_n, done_k;
  int          rd_k [2];
  int          wr_k [2];
  logic [29:0] rd_addr [2];
  logic [29:0] wr_addr [2];
  logic [31:0] wr_data [2];
  logic        o_split, o_mis, bus_clean, ready_after;

  task automatic start(input int d, input logic [31:0] a, input logic [1:0] s, input logic [31:0] v);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready_v[d] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_start", 64'(ready_v[d]), 64'd1);
    t_addr = a;
    t_size = s;
    t_data = v;
    req_valid_v[d] = 1'b1;
    @(posedge clk);
    #1;
    req_valid_v = '0;
  endtask

  task automatic observe(input int d);
    rd_n = 0; we_n = 0; done_k = 0;
    o_split = 1'b0; o_mis = 1'b0; bus_clean = 1'b1;
    for (int k = 1; k <= 60 && done_k == 0; k++) begin
      @(negedge clk);
      if (rd_v[d] && we_v[d]) bus_clean = 1'b0;
      if (ready_v[d] || !busy_v[d]) bus_clean = 1'b0;
      if (rd_v[d]) begin
        if (rd_n < 2) begin rd_k[rd_n] = k; rd_addr[rd_n] = raddr_v[d]; end
        rd_n++;
      end
      if (we_v[d]) begin
        if (we_n < 2) begin wr_k[we_n] = k; wr_addr[we_n] = raddr_v[d]; wr_data[we_n] = wdata_v[d]; end
        we_n++;
      end
      if (!rd_v[d] && !we_v[d] && (raddr_v[d] != 30'h0 || wdata_v[d] != 32'h0)) bus_clean = 1'b0;
      if (done_v[d]) begin
        done_k = k; o_split = split_v[d]; o_mis = mis_v[d];
      end else if (split_v[d] || mis_v[d]) begin
        bus_clean = 1'b0;
      end
    end
    check("done_within_budget", 64'(done_k != 0), 64'd1);
    @(negedge clk);
    ready_after = ready_v[d];
  endtask

  task automatic check_store(input string pfx, input int e_rd, input int e_we, input int e_done,
                             input logic e_split, input logic e_mis);
    check({pfx, "_reads"},    64'(rd_n),        64'(e_rd));
    check({pfx, "_writes"},   64'(we_n),        64'(e_we));
    check({pfx, "_done_cyc"}, 64'(done_k),      64'(e_done));
    check({pfx, "_split"},    64'(o_split),     64'(e_split));
    check({pfx, "_misalign"}, 64'(o_mis),       64'(e_mis));
    check({pfx, "_bus"},      64'(bus_clean),   64'd1);
    check({pfx, "_ready"},    64'(ready_after), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int bad;
    rst = 1'b1;
    req_valid_v = '0;
    t_addr = '0; t_size = '0; t_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // Reset values on all three engines.
    check("rst_ready",    64'(ready_v), 64'h7);
    check("rst_busy",     64'(busy_v),  64'h0);
    check("rst_strobes",  64'({rd_v, we_v}), 64'h0);
    check("rst_status",   64'({done_v, split_v, mis_v}), 64'h0);
    check("rst_ram_addr", 64'(raddr_v[0]), 64'h0);
    check("rst_ram_wdata", 64'(wdata_v[0]), 64'h0);
    rst = 1'b0;

    // Aligned full word: no read, write at t+1, done at t+2.
    start(0, 32'h100, SZ_W, 32'hDEADBEEF);
    observe(0);
    check_store("word_aligned", 0, 1, 2, 1'b0, 1'b0);
    check("word_aligned_wcyc",  64'(wr_k[0]),    64'd1);
    check("word_aligned_waddr", 64'(wr_addr[0]), 64'h40);
    check("word_aligned_wdata", 64'(wr_data[0]), 64'hDEADBEEF);

    // Dword clamps to one full word.
    start(0, 32'h200, SZ_D, 32'hCAFEF00D);
    observe(0);
    check_store("dword_clamp", 0, 1, 2, 1'b0, 1'b0);
    check("dword_clamp_waddr", 64'(wr_addr[0]), 64'h80);
    check("dword_clamp_wdata", 64'(wr_data[0]), 64'hCAFEF00D);

    // Byte into lane 1.
    mem[key(0, 30'h40)] = 32'h11223344;
    start(0, 32'h101, SZ_B, 32'h000000AA);
    observe(0);
    check_store("byte_lane1", 1, 1, 3, 1'b0, 1'b0);
    check("byte_lane1_rcyc",  64'(rd_k[0]),    64'd1);
    check("byte_lane1_raddr", 64'(rd_addr[0]), 64'h40);
    check("byte_lane1_wcyc",  64'(wr_k[0]),    64'd2);
    check("byte_lane1_wdata", 64'(wr_data[0]), 64'h1122AA44);

    // Half into the upper two lanes.
    mem[key(0, 30'h40)] = 32'h11223344;
    start(0, 32'h102, SZ_H, 32'h0000BEEF);
    observe(0);
    check_store("half_upper", 1, 1, 3, 1'b0, 1'b0);
    check("half_upper_wdata", 64'(wr_data[0]), 64'hBEEF3344);

    // Word at offset 3 splits across two words.
    mem[key(0, 30'h40)] = 32'h11223344;
    mem[key(0, 30'h41)] = 32'h55667788;
    start(0, 32'h103, SZ_W, 32'hA1B2C3D4);
    observe(0);
    check_store("split_word", 2, 2, 5, 1'b1, 1'b0);
    check("split_word_rcyc2",  64'(rd_k[1]),    64'd3);
    check("split_word_raddr2", 64'(rd_addr[1]), 64'h41);
    check("split_word_wcyc1",  64'(wr_k[0]),    64'd2);
    check("split_word_wdata1", 64'(wr_data[0]), 64'hD4223344);
    check("split_word_wcyc2",  64'(wr_k[1]),    64'd4);
    check("split_word_waddr2", 64'(wr_addr[1]), 64'h41);
    check("split_word_wdata2", 64'(wr_data[1]), 64'h55A1B2C3);

    // Same store with splitting disabled: spill dropped, misalign flagged.
    mem[key(2, 30'h40)] = 32'h11223344;
    mem[key(2, 30'h41)] = 32'h55667788;
    start(2, 32'h103, SZ_W, 32'hA1B2C3D4);
    observe(2);
    check_store("nosplit_word", 1, 1, 3, 1'b0, 1'b1);
    check("nosplit_word_wdata", 64'(wr_data[0]), 64'hD4223344);
    check("nosplit_word_next_untouched", 64'(mem_rd(2, 30'h41)), 64'h55667788);

    // RD_LAT=3 partial byte: read t+1, write t+4, done t+5.
    mem[key(1, 30'h0)] = 32'h99887766;
    start(1, 32'h0, SZ_B, 32'h0000005A);
    observe(1);
    check_store("lat3_byte", 1, 1, 5, 1'b0, 1'b0);
    check("lat3_byte_wcyc",  64'(wr_k[0]),    64'd4);
    check("lat3_byte_wdata", 64'(wr_data[0]), 64'h9988775A);

    // RD_LAT=3 half at the top of the address space: phase 2 wraps to word 0.
    mem[key(1, 30'h3FFFFFFF)] = 32'hAABBCCDD;
    mem[key(1, 30'h0)]        = 32'h99887766;
    start(1, 32'hFFFFFFFF, SZ_H, 32'h00001234);
    observe(1);
    check_store("wrap_half", 2, 2, 9, 1'b1, 1'b0);
    check("wrap_half_raddr1", 64'(rd_addr[0]), 64'h3FFFFFFF);
    check("wrap_half_wcyc1",  64'(wr_k[0]),    64'd4);
    check("wrap_half_wdata1", 64'(wr_data[0]), 64'h34BBCCDD);
    check("wrap_half_rcyc2",  64'(rd_k[1]),    64'd5);
    check("wrap_half_raddr2", 64'(rd_addr[1]), 64'h0);
    check("wrap_half_wcyc2",  64'(wr_k[1]),    64'd8);
    check("wrap_half_waddr2", 64'(wr_addr[1]), 64'h0);
    check("wrap_half_wdata2", 64'(wr_data[1]), 64'h99887712);

    // Reset during WAIT: no write, no done, idle the next cycle.
    mem[key(1, 30'h2)] = 32'hFFFFFFFF;
    start(1, 32'h8, SZ_B, 32'h00000077);
    @(negedge clk);
    check("rstwait_rd_cycle1", 64'(rd_v[1]), 64'd1);
    @(negedge clk);
    check("rstwait_in_wait", 64'({rd_v[1], we_v[1], ready_v[1]}), 64'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rstwait_ready_next", 64'(ready_v[1]), 64'd1);
    check("rstwait_busy_next",  64'(busy_v[1]),  64'd0);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (we_v[1] || rd_v[1] || done_v[1] || !ready_v[1]) bad++;
    end
    check("rstwait_quiet_after", 64'(bad), 64'd0);
    check("rstwait_word_kept", 64'(mem_rd(1, 30'h2)), 64'hFFFFFFFF);

    // Engine recovers and completes a normal store.
    mem[key(1, 30'h0)] = 32'h99887766;
    start(1, 32'h0, SZ_B, 32'h0000005A);
    observe(1);
    check_store("after_rst", 1, 1, 5, 1'b0, 1'b0);
    check("after_rst_wdata", 64'(wr_data[0]), 64'h9988775A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
